alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Sequencer and round-robin arbiter that lets two requesters share one combinational 16-bit ALU (operands `inp1`/`inp2`, 3-bit opcode, result plus overflow flag).
- Accepts one operation at a time over a valid/ready handshake.
- Holds the ALU inputs stable for a programmable settle time, then captures result and overflow.
- Returns the captured values with the requester ID over a valid/ready response channel.
- Keeps operation and overflow statistics.
- Sits between the datapath clients and the ALU instance.

## Interface
- `WIDTH`, 16, operand/result width
- `OPC_W`, 3, opcode width
- `SETTLE`, 1, cycles ALU inputs are held before capture; legal 1..15

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req0_valid`  in  1  requester 0 has an operation
- `req0_ready`  out  1  controller accepts requester 0 this cycle
- `req0_inp1`, `req0_inp2`  in  WIDTH  requester 0 operands
- `req0_opc`  in  OPC_W  requester 0 opcode
- `req1_valid`, `req1_ready`, `req1_inp1`, `req1_inp2`, `req1_opc`: same as requester 0, for requester 1
- `alu_inp1`, `alu_inp2`  out  WIDTH  registered ALU operands
- `alu_opc`  out  OPC_W  registered ALU opcode
- `alu_out`  in  WIDTH  ALU result
- `alu_overflow`  in  1  ALU overflow flag
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer takes response
- `rsp_id`  out  1  requester that issued the operation
- `rsp_out`  out  WIDTH  captured result
- `rsp_overflow`  out  1  captured overflow
- `busy`  out  1  state is not IDLE
- `ops_done`  out  16  completed responses; wraps 0xFFFF→0
- `ovf_count`  out  8  responses with `rsp_overflow`=1; saturates at 0xFF

## Operation
- States: IDLE, WAIT, RESP.
- Reset values:
  - State is IDLE; all registered outputs are 0.
  - `last_grant` is 1, so requester 0 wins the first tie.
  - `req0_ready` and `req1_ready` are 0 while `rst` is high.
- IDLE, arbitration:
  - If only one valid is high, that requester wins.
  - If both are high, the requester ≠ `last_grant` wins.
  - Only the winner's ready is high; ready is combinational from valid and `last_grant`, and only in IDLE.
  - Never more than one ready high; both ready are low in WAIT and RESP.
- Accept (winner valid&ready at a rising edge):
  - Load winner operands/opcode into `alu_inp1`/`alu_inp2`/`alu_opc`; load winner into `rsp_id` and `last_grant`.
  - Load settle counter with `SETTLE`-1; go to WAIT.
- WAIT:
  - ALU inputs do not change.
  - Counter decrements each cycle. When it reads 0 at an edge: capture `alu_out`→`rsp_out` and `alu_overflow`→`rsp_overflow`, set `rsp_valid`, go to RESP.
- RESP:
  - `rsp_*` are held stable until `rsp_valid`&`rsp_ready` at an edge.
  - At that edge: clear `rsp_valid`, increment `ops_done`, increment `ovf_count` if `rsp_overflow` (saturating), go to IDLE.
- `rsp_ready` is ignored outside RESP.
- ALU input registers retain their last operation after completion; they change only on accept or reset.
- Requester valid dropping before grant is legal; nothing is latched.
- Reset mid-operation (WAIT or RESP): state, outputs and counters return to reset values. The pending response is discarded and never presented.

## Timing
- Accept at edge E: ALU inputs are new from cycle E+1.
- Capture at edge E+`SETTLE`; `rsp_valid` is high from cycle E+`SETTLE`+1.
- With `SETTLE`=1: `rsp_valid` is high 2 cycles after accept.
- Response taken at edge R: IDLE in cycle R+1; a ready may be high in cycle R+1.
- Minimum spacing between accepts is `SETTLE`+2 cycles, assuming `rsp_ready` is tied high.
- `busy` is registered: high from the cycle after accept through the cycle of the response-taking edge.
- Counters update on the response-taking edge and are visible in the next cycle.

## Test plan
Bench stub ALU: `alu_out` = `alu_inp1`+`alu_inp2` mod 2^16; `alu_overflow` = signed-add overflow.
1. Reset, then `req0_valid`, inputs 0x0002/0x0008, opc 3'b001, `rsp_ready`=1, `SETTLE`=1 → `alu_opc`=3'b001 in cycle E+1; `rsp_valid` in E+2 with `rsp_id`=0, `rsp_out`=0x000A, `rsp_overflow`=0; `ops_done`=1.
2. Requester 1 sends 0x7FFF+0x0001 → `rsp_out`=0x8000, `rsp_overflow`=1, `rsp_id`=1; `ovf_count` increments to 1.
3. Both valid continuously for 4 ops → grant order 0,1,0,1; never both ready high; ready is 0 during WAIT/RESP.
4. `rsp_ready`=0 for 5 cycles in RESP while `req0_valid`=1 → `rsp_*` stable; `req0_ready` stays 0; `rsp_ready` high → IDLE next cycle, then accept.
5. `rst` pulsed during WAIT (`SETTLE`=4) → no `rsp_valid` ever appears; all outputs 0; `ops_done`=0; next tie grants requester 0.
6. `SETTLE`=15 plus 256 overflow ops → `rsp_valid` exactly 16 cycles after each accept; `ovf_count` saturates at 0xFF; `ops_done`=256.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Two-requester front end for a shared combinational ALU: round-robin grant,
// operand hold for a settle window, captured result on a response channel.
module alu_share_ctrl #(
    parameter int WIDTH  = 16,
    parameter int OPC_W  = 3,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_inp1,
    input  logic [WIDTH-1:0] req0_inp2,
    input  logic [OPC_W-1:0] req0_opc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_inp1,
    input  logic [WIDTH-1:0] req1_inp2,
    input  logic [OPC_W-1:0] req1_opc,
    output logic [WIDTH-1:0] alu_inp1,
    output logic [WIDTH-1:0] alu_inp2,
    output logic [OPC_W-1:0] alu_opc,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_overflow,
    output logic             busy,
    output logic [15:0]      ops_done,
    output logic [7:0]       ovf_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    logic [1:0]       r_state;
    logic             r_last_grant;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_alu_inp1;
    logic [WIDTH-1:0] r_alu_inp2;
    logic [OPC_W-1:0] r_alu_opc;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_out;
    logic             r_rsp_ovf;
    logic             r_busy;
    logic [15:0]      r_ops_done;
    logic [7:0]       r_ovf_count;

    logic             w_idle;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_acc;
    logic [WIDTH-1:0] w_inp1;
    logic [WIDTH-1:0] w_inp2;
    logic [OPC_W-1:0] w_opc;

    // On a tie the requester that did not win last time gets the grant.
    assign w_idle = (r_state == S_IDLE) && !rst;
    assign w_gnt0 = w_idle && req0_valid && (!req1_valid || r_last_grant);
    assign w_gnt1 = w_idle && req1_valid && (!req0_valid || !r_last_grant);
    assign w_acc  = w_gnt0 || w_gnt1;

    assign w_inp1 = w_gnt1 ? req1_inp1 : req0_inp1;
    assign w_inp2 = w_gnt1 ? req1_inp2 : req0_inp2;
    assign w_opc  = w_gnt1 ? req1_opc  : req0_opc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_alu_inp1   <= '0;
            r_alu_inp2   <= '0;
            r_alu_opc    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_out    <= '0;
            r_rsp_ovf    <= 1'b0;
            r_busy       <= 1'b0;
            r_ops_done   <= '0;
            r_ovf_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_alu_inp1   <= w_inp1;
                        r_alu_inp2   <= w_inp2;
                        r_alu_opc    <= w_opc;
                        r_rsp_id     <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_cnt        <= CNT_INIT;
                        r_busy       <= 1'b1;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_out   <= alu_out;
                        r_rsp_ovf   <= alu_overflow;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_ops_done  <= r_ops_done + 16'd1;
                        if (r_rsp_ovf && (r_ovf_count != 8'hFF))
                            r_ovf_count <= r_ovf_count + 8'd1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req0_ready   = w_gnt0;
    assign req1_ready   = w_gnt1;
    assign alu_inp1     = r_alu_inp1;
    assign alu_inp2     = r_alu_inp2;
    assign alu_opc      = r_alu_opc;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_out      = r_rsp_out;
    assign rsp_overflow = r_rsp_ovf;
    assign busy         = r_busy;
    assign ops_done     = r_ops_done;
    assign ovf_count    = r_ovf_count;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: three instances (SETTLE 1, 4, 15), each with an
// adder stub ALU, driven by vector tables and hand sequences.
module tb_alu_share_ctrl;

    typedef struct {
        bit          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  opc;
        logic [15:0] eo;
        bit          eov;
    } vec_t;

    typedef struct {
        bit          id;
        logic [15:0] out;
        bit          ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0[3];
    logic        v1[3];
    logic        rr[3];
    logic [15:0] a0[3];
    logic [15:0] b0[3];
    logic [15:0] a1[3];
    logic [15:0] b1[3];
    logic [2:0]  o0[3];
    logic [2:0]  o1[3];

    logic        r0rdy[3];
    logic        r1rdy[3];
    logic [15:0] alu_a[3];
    logic [15:0] alu_b[3];
    logic [2:0]  aop[3];
    logic [15:0] alu_res[3];
    logic        alu_ov[3];
    logic        rv[3];
    logic        rid[3];
    logic [15:0] rout[3];
    logic        rovf[3];
    logic        bsy[3];
    logic [15:0] ops[3];
    logic [7:0]  ovfc[3];

    int   n_pass = 0;
    int   n_tot  = 0;
    int   viol   = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign alu_res[g] = alu_a[g] + alu_b[g];
        assign alu_ov[g]  = (alu_a[g][15] == alu_b[g][15]) &&
                            (alu_res[g][15] != alu_a[g][15]);
        alu_share_ctrl #(
            .WIDTH (16),
            .OPC_W (3),
            .SETTLE(g == 0 ? 1 : (g == 1 ? 4 : 15))
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .req0_valid  (v0[g]),
            .req0_ready  (r0rdy[g]),
            .req0_inp1   (a0[g]),
            .req0_inp2   (b0[g]),
            .req0_opc    (o0[g]),
            .req1_valid  (v1[g]),
            .req1_ready  (r1rdy[g]),
            .req1_inp1   (a1[g]),
            .req1_inp2   (b1[g]),
            .req1_opc    (o1[g]),
            .alu_inp1    (alu_a[g]),
            .alu_inp2    (alu_b[g]),
            .alu_opc     (aop[g]),
            .alu_out     (alu_res[g]),
            .alu_overflow(alu_ov[g]),
            .rsp_valid   (rv[g]),
            .rsp_ready   (rr[g]),
            .rsp_id      (rid[g]),
            .rsp_out     (rout[g]),
            .rsp_overflow(rovf[g]),
            .busy        (bsy[g]),
            .ops_done    (ops[g]),
            .ovf_count   (ovfc[g])
        );
    end

    // Ready exclusivity, ready low while busy, ready low in reset.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (r0rdy[k] && r1rdy[k]) viol++;
            if (bsy[k] && (r0rdy[k] || r1rdy[k])) viol++;
            if (rst && (r0rdy[k] || r1rdy[k])) viol++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic int st(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 15);
    endfunction

    function automatic logic rdy(input int k, input bit id);
        return id ? r1rdy[k] : r0rdy[k];
    endfunction

    task automatic drive(input int k, input bit id, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] opc);
        if (!id) begin
            a0[k] = a; b0[k] = b; o0[k] = opc; v0[k] = 1'b1;
        end else begin
            a1[k] = a; b1[k] = b; o1[k] = opc; v1[k] = 1'b1;
        end
    endtask

    task automatic rsp_pop(input int k);
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'(sbq.size()), 32'd1);
        end else begin
            e = sbq.pop_front();
            chk("rsp_id", 32'(rid[k]), 32'(e.id));
            chk("rsp_out", 32'(rout[k]), 32'(e.out));
            chk("rsp_ovf", 32'(rovf[k]), 32'(e.ovf));
        end
    endtask

    task automatic push_exp(input bit id, input logic [15:0] o, input bit ov);
        exp_t e;
        e.id = id; e.out = o; e.ovf = ov;
        sbq.push_back(e);
    endtask

    // One full operation with rsp_ready high; leaves the DUT idle.
    task automatic do_op(input int k, input bit id, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] opc,
                         input logic [15:0] eo, input bit eov);
        int t;
        int lat;
        @(negedge clk);
        rr[k] = 1'b1;
        drive(k, id, a, b, opc);
        #1;
        t = 0;
        while (!rdy(k, id) && t < 50) begin
            @(negedge clk); #1; t++;
        end
        chk("grant", 32'(rdy(k, id)), 32'd1);
        push_exp(id, eo, eov);
        @(posedge clk); #1;
        v0[k] = 1'b0; v1[k] = 1'b0;
        @(negedge clk);
        chk("alu_opc", 32'(aop[k]), 32'(opc));
        chk("alu_inp", {alu_a[k], alu_b[k]}, {a, b});
        lat = 1;
        while (!rv[k] && lat < 40) begin
            @(negedge clk); lat++;
        end
        chk("latency", 32'(lat), 32'(st(k) + 1));
        rsp_pop(k);
        @(posedge clk);
        @(negedge clk);
        chk("idle_after", 32'(bsy[k]), 32'd0);
    endtask

    initial begin
        vec_t vt[5];
        int   ovf_exp;
        bit   grants[$];
        int   nacc;
        int   nresp;
        int   t;
        int   bad;
        int   seen;

        vt[0] = '{1'b0, 16'h0002, 16'h0008, 3'b001, 16'h000A, 1'b0};
        vt[1] = '{1'b1, 16'h7FFF, 16'h0001, 3'b101, 16'h8000, 1'b1};
        vt[2] = '{1'b0, 16'hFFFF, 16'h0001, 3'b010, 16'h0000, 1'b0};
        vt[3] = '{1'b1, 16'h8000, 16'h8000, 3'b111, 16'h0000, 1'b1};
        vt[4] = '{1'b1, 16'h1234, 16'h1111, 3'b100, 16'h2345, 1'b0};

        for (int k = 0; k < 3; k++) begin
            v0[k] = 0; v1[k] = 0; rr[k] = 1;
            a0[k] = 0; b0[k] = 0; a1[k] = 0; b1[k] = 0;
            o0[k] = 0; o1[k] = 0;
        end

        // Reset: ready must stay low even with a valid present.
        v0[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rdy_in_reset", 32'(r0rdy[0]), 32'd0);
        rst = 1'b0;
        v0[0] = 1'b0;
        #1;
        chk("rst_alu", {alu_a[0], alu_b[0]}, 32'd0);
        chk("rst_opc", 32'(aop[0]), 32'd0);
        chk("rst_rsp", {14'd0, rv[0], rid[0], rout[0]}, 32'd0);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chk("rst_cnt", {8'd0, ops[0], ovfc[0]}, 32'd0);

        // Table-driven single operations on the SETTLE=1 instance.
        ovf_exp = 0;
        for (int i = 0; i < 5; i++) begin
            do_op(0, vt[i].id, vt[i].a, vt[i].b, vt[i].opc,
                  vt[i].eo, vt[i].eov);
            if (vt[i].eov) ovf_exp++;
            chk("ops_done", 32'(ops[0]), 32'(i + 1));
            chk("ovf_count", 32'(ovfc[0]), 32'(ovf_exp));
        end

        // Both requesters valid continuously: alternating grants.
        @(negedge clk);
        drive(0, 1'b0, 16'h0100, 16'h0001, 3'b011);
        drive(0, 1'b1, 16'h0200, 16'h0002, 3'b110);
        #1;
        nacc = 0; nresp = 0; t = 0;
        while (nresp < 4 && t < 200) begin
            if (rv[0]) begin
                rsp_pop(0);
                nresp++;
            end
            if (r0rdy[0] || r1rdy[0]) begin
                grants.push_back(r1rdy[0]);
                if (r1rdy[0]) push_exp(1'b1, 16'h0202, 1'b0);
                else          push_exp(1'b0, 16'h0101, 1'b0);
                nacc++;
                if (nacc == 4) begin
                    @(posedge clk); #1;
                    v0[0] = 1'b0; v1[0] = 1'b0;
                end
            end
            @(negedge clk); #1;
            t++;
        end
        chk("rr_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk("rr_order", 32'(grants[i]), 32'(i % 2));
        chk("rr_ops", 32'(ops[0]), 32'd9);

        // Backpressure: response held while rsp_ready is low.
        @(negedge clk);
        rr[0] = 1'b0;
        drive(0, 1'b0, 16'h0003, 16'h0004, 3'b010);
        #1;
        chk("bp_grant", 32'(r0rdy[0]), 32'd1);
        push_exp(1'b0, 16'h0007, 1'b0);
        @(posedge clk); #1;
        t = 0;
        while (!rv[0] && t < 40) begin
            @(negedge clk); t++;
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!rv[0] || rout[0] !== 16'h0007 || rid[0] !== 1'b0 ||
                rovf[0] !== 1'b0 || r0rdy[0] !== 1'b0)
                bad++;
            @(negedge clk);
        end
        chk("bp_hold", 32'(bad), 32'd0);
        chk("bp_still_valid", 32'(rv[0]), 32'd1);
        rr[0] = 1'b1;
        rsp_pop(0);
        @(posedge clk);
        @(negedge clk); #1;
        chk("bp_idle", 32'(bsy[0]), 32'd0);
        chk("bp_regrant", 32'(r0rdy[0]), 32'd1);
        push_exp(1'b0, 16'h0007, 1'b0);
        @(posedge clk); #1;
        v0[0] = 1'b0;
        t = 0;
        while (!rv[0] && t < 40) begin
            @(negedge clk); t++;
        end
        rsp_pop(0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_ops", 32'(ops[0]), 32'd11);

        // Reset during WAIT on the SETTLE=4 instance.
        do_op(1, 1'b1, 16'h0010, 16'h0020, 3'b011, 16'h0030, 1'b0);
        chk("b_ops_pre", 32'(ops[1]), 32'd1);
        @(negedge clk);
        drive(1, 1'b0, 16'h0005, 16'h0006, 3'b001);
        #1;
        chk("b_grant", 32'(r0rdy[1]), 32'd1);
        @(posedge clk); #1;
        v0[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b_in_wait", {30'd0, bsy[1], rv[1]}, 32'd2);
        rst = 1'b1;
        v1[1] = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        chk("rdy_rst_idle", 32'(r1rdy[1]), 32'd0);
        rst = 1'b0;
        v1[1] = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (rv[1]) seen++;
        end
        chk("no_rsp_after_rst", 32'(seen), 32'd0);
        chk("b_rst_alu", {alu_a[1], alu_b[1]}, 32'd0);
        chk("b_rst_opc", 32'(aop[1]), 32'd0);
        chk("b_rst_rsp", {14'd0, rid[1], rovf[1], rout[1]}, 32'd0);
        chk("b_rst_busy", 32'(bsy[1]), 32'd0);
        chk("b_ops_zero", 32'(ops[1]), 32'd0);
        chk("b_ovf_zero", 32'(ovfc[1]), 32'd0);
        v0[1] = 1'b1; v1[1] = 1'b1;
        #1;
        chk("b_tie", {30'd0, r0rdy[1], r1rdy[1]}, 32'd2);
        v0[1] = 1'b0; v1[1] = 1'b0;

        // SETTLE=15 with overflow saturation.
        for (int i = 0; i < 256; i++) begin
            do_op(2, 1'(i % 2), 16'h7FFF, 16'h0001, 3'b000, 16'h8000, 1'b1);
            if (i == 253) chk("c_ovf_254", 32'(ovfc[2]), 32'hFE);
            if (i == 254) chk("c_ovf_255", 32'(ovfc[2]), 32'hFF);
        end
        chk("c_ovf_sat", 32'(ovfc[2]), 32'hFF);
        chk("c_ops", 32'(ops[2]), 32'd256);

        chk("ready_rules", 32'(viol), 32'd0);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
